// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Memory-stage access controller. It sits between the MEM pipeline stage and a
// multi-cycle data memory (e.g. stallmem). One load/store request is latched
// from the pipeline, and the memory handshake is driven from the latched copy.
// The pipeline is held with pipe_stall until the access finishes. Completion
// is signalled with a one-cycle resp_valid pulse, qualified by resp_err.
// Memory errors and timeouts are reported per access (resp_err) and through a
// sticky flag (err_sticky) that only rst clears.
//
// Optional feature (compile-time macro MEM_MISALIGN_CHK_EN):
//   When defined, a request whose req_addr[0] is 1 is rejected straight from
//   IDLE into ERR without touching memory. When undefined, addresses go to
//   memory unmodified.
//
// Parameters:
//   DATA_W   data bus width
//   ADDR_W   address bus width
//   TIMEOUT  max cycles spent in ISSUE+WAIT before abort (>= 2)
//   CNT_W    wait-counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_rd, req_wr      pipeline load / store request (store wins if both)
//   req_addr, req_wdata access address and store data
//   req_dump            dump request, forwarded to mem_dump only in IDLE
//   pipe_stall          hold the pipeline
//   resp_valid          one-cycle completion pulse
//   resp_err            qualifies resp_valid: access failed
//   rdata               data of the last successful load
//   err_sticky          set on any error, cleared by rst only
//   mem_addr, mem_wdata memory address / write data (latched copies)
//   mem_rd, mem_wr      memory strobes, active in ISSUE only
//   mem_dump            memory createdump
//   mem_rdata           memory read data
//   mem_done            memory access complete, read data valid
//   mem_stall           memory busy, request not accepted
//   mem_err             memory error

module mem_access_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   // Pipeline side
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_dump,
   output logic              pipe_stall,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] rdata,
   output logic              err_sticky,
   // Memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              mem_dump,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_stall,
   input  logic              mem_err
);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StResp,
      StErr
   } state_e;

   localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

   state_e              state_q, state_d;
   logic                op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_sticky_q, err_sticky_d;

   logic                req_any;
   logic                timeout_hit;
   logic [CNT_W-1:0]    cnt_inc;

   assign req_any = req_rd | req_wr;

   // >= rather than == so an access that moves ISSUE->WAIT on the limit
   // cycle still times out on the next WAIT cycle.
   assign timeout_hit = (cnt_q >= CntLimit);

   // Saturating increment: the counter never wraps back to zero.
   assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state and output logic
   always_comb begin
      state_d      = state_q;
      op_wr_d      = op_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      err_sticky_d = err_sticky_q;

      pipe_stall   = 1'b0;
      resp_valid   = 1'b0;
      resp_err     = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_dump     = 1'b0;

      unique case (state_q)
         StIdle: begin
            pipe_stall = req_any;
            mem_dump   = req_dump;
            if (req_any) begin
               op_wr_d = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = '0;
`ifdef MEM_MISALIGN_CHK_EN
               // Odd addresses never reach memory; fail the access at once.
               state_d = req_addr[0] ? StErr : StIssue;
`else
               state_d = StIssue;
`endif
            end
         end

         StIssue: begin
            pipe_stall = 1'b1;
            mem_rd     = ~op_wr_q;
            mem_wr     = op_wr_q;
            cnt_d      = cnt_inc;
            if (mem_err) begin
               state_d = StErr;
            end else if (mem_done) begin
               state_d = StResp;
               if (!op_wr_q) begin
                  rdata_d = mem_rdata;
               end
            end else if (!mem_stall) begin
               state_d = StWait;
            end else if (timeout_hit) begin
               state_d = StErr;
            end
         end

         StWait: begin
            pipe_stall = 1'b1;
            cnt_d      = cnt_inc;
            if (mem_err) begin
               state_d = StErr;
            end else if (mem_done) begin
               state_d = StResp;
               if (!op_wr_q) begin
                  rdata_d = mem_rdata;
               end
            end else if (timeout_hit) begin
               state_d = StErr;
            end
         end

         // Requests seen here still belong to the completing instruction.
         StResp: begin
            resp_valid = 1'b1;
            state_d    = StIdle;
         end

         StErr: begin
            resp_valid   = 1'b1;
            resp_err     = 1'b1;
            err_sticky_d = 1'b1;
            state_d      = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         op_wr_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_wr_q      <= op_wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   // Memory address/data come from the latched request so they stay stable
   // for the whole access regardless of what the pipeline does meanwhile.
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign rdata      = rdata_q;
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 ns later, mid-cycle.

module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        req_rd;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_dump;
   logic        pipe_stall;
   logic        resp_valid;
   logic        resp_err;
   logic [15:0] rdata;
   logic        err_sticky;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_dump;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        mem_stall;
   logic        mem_err;

   int unsigned n_pass;
   int unsigned n_total;

   mem_access_ctrl #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .TIMEOUT (64),
      .CNT_W   (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_rd     (req_rd),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_dump   (req_dump),
      .pipe_stall (pipe_stall),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .rdata      (rdata),
      .err_sticky (err_sticky),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_dump   (mem_dump),
      .mem_rdata  (mem_rdata),
      .mem_done   (mem_done),
      .mem_stall  (mem_stall),
      .mem_err    (mem_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      logic [56:0] outs;
      rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      req_dump = 1'b0; mem_rdata = '0; mem_done = 1'b0; mem_stall = 1'b0; mem_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         outs = {pipe_stall, resp_valid, resp_err, err_sticky, mem_rd, mem_wr, mem_dump,
                 rdata, mem_addr, mem_wdata, 2'b00};
         n_total++;
         if (outs !== 57'd0) $display("FAIL reset_idle_c%0d got %h want 0", i, outs);
         else n_pass++;
      end
   endtask

   task automatic test_read_zero_wait();
      // Cycle 0: IDLE with request
      @(negedge clk); req_rd = 1'b1; req_addr = 16'h0010; #1;
      n_total++; if (pipe_stall !== 1'b1 || mem_rd !== 1'b0)
         $display("FAIL rd0_idle stall=%b rd=%b want 1 0", pipe_stall, mem_rd); else n_pass++;
      // Cycle 1: ISSUE, memory answers at once
      @(negedge clk); mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
      n_total++; if (pipe_stall !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 16'h0010)
         $display("FAIL rd0_issue stall=%b rd=%b addr=%h want 1 1 0010",
                  pipe_stall, mem_rd, mem_addr); else n_pass++;
      // Cycle 2: RESP (request still held, must be ignored)
      @(negedge clk); mem_done = 1'b0; mem_rdata = '0; #1;
      n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || pipe_stall !== 1'b0 ||
                     rdata !== 16'hBEEF || mem_rd !== 1'b0)
         $display("FAIL rd0_resp v=%b e=%b stall=%b rdata=%h rd=%b want 1 0 0 beef 0",
                  resp_valid, resp_err, pipe_stall, rdata, mem_rd); else n_pass++;
      // Cycle 3: back in IDLE
      @(negedge clk); req_rd = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b0 || pipe_stall !== 1'b0 || mem_rd !== 1'b0 ||
                     rdata !== 16'hBEEF)
         $display("FAIL rd0_idle_after v=%b stall=%b rd=%b rdata=%h want 0 0 0 beef",
                  resp_valid, pipe_stall, mem_rd, rdata); else n_pass++;
   endtask

   task automatic test_write_stalled();
      int wr_cycles = 0;
      @(negedge clk); req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
      mem_stall = 1'b1; #1;
      n_total++; if (pipe_stall !== 1'b1 || mem_wr !== 1'b0)
         $display("FAIL wr_idle stall=%b wr=%b want 1 0", pipe_stall, mem_wr); else n_pass++;
      // 3 ISSUE cycles stalled, 1 accepted, then WAIT, done in 2nd WAIT cycle
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk); mem_stall = (i <= 3); mem_done = (i == 6); mem_rdata = 16'hDEAD; #1;
         if (mem_wr === 1'b1) wr_cycles++;
         n_total++; if (mem_addr !== 16'h0020 || mem_wdata !== 16'h1234 || pipe_stall !== 1'b1)
            $display("FAIL wr_hold_c%0d addr=%h wdata=%h stall=%b want 0020 1234 1",
                     i, mem_addr, mem_wdata, pipe_stall); else n_pass++;
      end
      @(negedge clk); mem_done = 1'b0; req_wr = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || rdata !== 16'hBEEF ||
                     mem_wr !== 1'b0)
         $display("FAIL wr_resp v=%b e=%b rdata=%h wr=%b want 1 0 beef 0",
                  resp_valid, resp_err, rdata, mem_wr); else n_pass++;
      n_total++; if (wr_cycles !== 4)
         $display("FAIL wr_strobe_len got %0d want 4", wr_cycles); else n_pass++;
   endtask

   task automatic test_timeout();
      int bad = 0;
      logic [15:0] exp;
      @(negedge clk); req_rd = 1'b1; req_addr = 16'h0030; mem_stall = 1'b0; #1;
      // 64 ISSUE/WAIT cycles with no response; ERR follows the 64th
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk); #1;
         if (resp_valid !== 1'b0 || pipe_stall !== 1'b1) bad++;
      end
      n_total++; if (bad !== 0)
         $display("FAIL to_wait_cycles bad=%0d want 0", bad); else n_pass++;
      @(negedge clk); req_rd = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || pipe_stall !== 1'b0 ||
                     rdata !== 16'hBEEF)
         $display("FAIL to_err v=%b e=%b stall=%b rdata=%h want 1 1 0 beef",
                  resp_valid, resp_err, pipe_stall, rdata); else n_pass++;
      @(negedge clk); #1;
      n_total++; if (err_sticky !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL to_sticky sticky=%b v=%b want 1 0", err_sticky, resp_valid);
      else n_pass++;
      // Five good zero-wait reads; sticky flag must survive them
      for (int k = 0; k < 5; k++) begin
         exp = 16'(k * 16'h1111 + 1);
         @(negedge clk); req_rd = 1'b1; req_addr = 16'(16'h0040 + k);
         @(negedge clk); mem_done = 1'b1; mem_rdata = exp;
         @(negedge clk); mem_done = 1'b0; req_rd = 1'b0; #1;
         n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || rdata !== exp ||
                        err_sticky !== 1'b1)
            $display("FAIL to_good%0d v=%b e=%b rdata=%h sticky=%b want 1 0 %h 1",
                     k, resp_valid, resp_err, rdata, err_sticky, exp); else n_pass++;
      end
   endtask

   task automatic test_mem_err();
      // mem_err outranks a simultaneous mem_done; rdata keeps the last good value
      @(negedge clk); req_rd = 1'b1; req_addr = 16'h0060;
      @(negedge clk); mem_err = 1'b1; mem_done = 1'b1; mem_rdata = 16'h7777;
      @(negedge clk); mem_err = 1'b0; mem_done = 1'b0; req_rd = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || rdata !== 16'h4445)
         $display("FAIL merr_resp v=%b e=%b rdata=%h want 1 1 4445",
                  resp_valid, resp_err, rdata); else n_pass++;
   endtask

   task automatic test_priority_dump();
      @(negedge clk); req_dump = 1'b1; #1;
      n_total++; if (mem_dump !== 1'b1 || pipe_stall !== 1'b0)
         $display("FAIL dump_idle dump=%b stall=%b want 1 0", mem_dump, pipe_stall);
      else n_pass++;
      @(negedge clk); req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0070;
      req_wdata = 16'h00AA; #1;
      n_total++; if (mem_dump !== 1'b1 || pipe_stall !== 1'b1)
         $display("FAIL dump_req dump=%b stall=%b want 1 1", mem_dump, pipe_stall);
      else n_pass++;
      @(negedge clk); mem_done = 1'b1; mem_rdata = 16'h3333; #1;
      n_total++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_dump !== 1'b0 ||
                     mem_wdata !== 16'h00AA)
         $display("FAIL prio_issue wr=%b rd=%b dump=%b wdata=%h want 1 0 0 00aa",
                  mem_wr, mem_rd, mem_dump, mem_wdata); else n_pass++;
      @(negedge clk); mem_done = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b1 || mem_dump !== 1'b0 || rdata !== 16'h4445)
         $display("FAIL prio_resp v=%b dump=%b rdata=%h want 1 0 4445",
                  resp_valid, mem_dump, rdata); else n_pass++;
      @(negedge clk); req_rd = 1'b0; req_wr = 1'b0; req_dump = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk); req_rd = 1'b1; req_addr = 16'h0050;
      @(negedge clk); mem_stall = 1'b0;
      @(negedge clk); #1;
      n_total++; if (mem_rd !== 1'b0 || pipe_stall !== 1'b1 || mem_addr !== 16'h0050)
         $display("FAIL rstm_wait1 rd=%b stall=%b addr=%h want 0 1 0050",
                  mem_rd, pipe_stall, mem_addr); else n_pass++;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; req_rd = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5555; #1;
      n_total++; if (mem_rd !== 1'b0 || pipe_stall !== 1'b0 || rdata !== 16'h0000 ||
                     err_sticky !== 1'b0 || resp_valid !== 1'b0 || mem_addr !== 16'h0000)
         $display("FAIL rstm_after rd=%b stall=%b rdata=%h sticky=%b v=%b addr=%h want 0 0 0 0 0 0",
                  mem_rd, pipe_stall, rdata, err_sticky, resp_valid, mem_addr); else n_pass++;
      @(negedge clk); mem_done = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b0 || rdata !== 16'h0000)
         $display("FAIL rstm_late_done v=%b rdata=%h want 0 0000", resp_valid, rdata);
      else n_pass++;
   endtask

   task automatic test_misalign();
      @(negedge clk); req_rd = 1'b1; req_addr = 16'h0011; #1;
      n_total++; if (pipe_stall !== 1'b1)
         $display("FAIL mis_idle stall=%b want 1", pipe_stall); else n_pass++;
      @(negedge clk); req_rd = 1'b0; mem_done = 1'b1; mem_rdata = 16'hA5A5; #1;
`ifdef MEM_MISALIGN_CHK_EN
      n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_rd !== 1'b0 ||
                     pipe_stall !== 1'b0)
         $display("FAIL mis_err v=%b e=%b rd=%b stall=%b want 1 1 0 0",
                  resp_valid, resp_err, mem_rd, pipe_stall); else n_pass++;
      @(negedge clk); mem_done = 1'b0; #1;
      n_total++; if (mem_rd !== 1'b0 || rdata !== 16'h0000 || err_sticky !== 1'b1)
         $display("FAIL mis_after rd=%b rdata=%h sticky=%b want 0 0000 1",
                  mem_rd, rdata, err_sticky); else n_pass++;
`else
      n_total++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0011 || pipe_stall !== 1'b1)
         $display("FAIL mis_issue rd=%b addr=%h stall=%b want 1 0011 1",
                  mem_rd, mem_addr, pipe_stall); else n_pass++;
      @(negedge clk); mem_done = 1'b0; #1;
      n_total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || rdata !== 16'hA5A5)
         $display("FAIL mis_resp v=%b e=%b rdata=%h want 1 0 a5a5",
                  resp_valid, resp_err, rdata); else n_pass++;
`endif
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_read_zero_wait();
      test_write_stalled();
      test_timeout();
      test_mem_err();
      test_priority_dump();
      test_reset_mid_access();
      test_misalign();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Parametrised memory-stage access controller that sits between the MEM pipeline stage and a multi-cycle data memory such as stallmem. It latches one load/store request from the pipeline and drives the memory handshake. It holds the pipeline with a stall signal until the access completes and returns registered read data with a one-cycle response strobe. It also detects memory errors and timeouts and reports them both per-access and as a sticky flag.

Parameters:
DATA_W, 16, data bus width in bits.
ADDR_W, 16, address bus width in bits.
TIMEOUT, 64, maximum cycles an access may spend in ISSUE+WAIT before it is aborted as an error; must be at least 2.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
req_rd  in  1  pipeline load request.
req_wr  in  1  pipeline store request; if both req_rd and req_wr are set, the write takes priority.
req_addr  in  ADDR_W  access address (ALU result).
req_wdata  in  DATA_W  store data.
req_dump  in  1  memory dump request; forwarded only while in IDLE.
pipe_stall  out  1  hold the pipeline.
resp_valid  out  1  one-cycle pulse: access complete.
resp_err  out  1  qualifies resp_valid: the access failed.
rdata  out  DATA_W  last completed load data.
err_sticky  out  1  set on any error; cleared only by rst.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rd  out  1  memory read strobe.
mem_wr  out  1  memory write strobe.
mem_dump  out  1  memory createdump.
mem_rdata  in  DATA_W  memory read data.
mem_done  in  1  memory access complete; read data valid.
mem_stall  in  1  memory busy; request not accepted.
mem_err  in  1  memory error.

Behaviour:
- Reset: state IDLE; all outputs 0, including rdata, err_sticky and every mem_* output. The counter and latched request are cleared. Reset mid-access aborts it: mem_rd/mem_wr are 0 from the cycle after rst.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - If req_rd or req_wr: latch op, addr and wdata, clear the counter, go to ISSUE.
  - pipe_stall = req_rd | req_wr, combinational.
  - mem_dump = req_dump, combinational; 0 in every other state.
- ISSUE:
  - mem_rd/mem_wr driven from the latched op; mem_addr/mem_wdata from the latched registers.
  - Transitions, in priority order:
    - mem_err goes to ERR.
    - mem_done goes to RESP; on a read, rdata <= mem_rdata.
    - !mem_stall goes to WAIT (request accepted).
    - Otherwise stay in ISSUE.
  - Counter increments each cycle. When counter == TIMEOUT-1 and none of the above has occurred, go to ERR.
- WAIT:
  - mem_rd/mem_wr are 0; mem_addr is held.
  - mem_err goes to ERR; mem_done goes to RESP and captures rdata on a read; timeout as in ISSUE; otherwise stay.
- RESP: resp_valid=1, resp_err=0, pipe_stall=0 for one cycle, then IDLE. Request inputs seen in RESP are ignored, because they still belong to the completing instruction.
- ERR: resp_valid=1, resp_err=1, pipe_stall=0 for one cycle; err_sticky <= 1; rdata unchanged; then IDLE.
- pipe_stall is 1 throughout ISSUE and WAIT.
- rdata holds its value until the next successful read; writes never modify it.
- Minimum latency with a zero-wait memory is 3 cycles: IDLE, ISSUE with mem_done, RESP. That is 2 stall cycles.
- Counter saturates; it never wraps.

Optional Feature:
MEM_MISALIGN_CHK_EN
- Defined: in IDLE, a request with req_addr[0]==1 latches the request and goes directly to ERR. No mem_rd/mem_wr is ever asserted for it. The stall lasts 1 cycle (the IDLE cycle), followed by a resp_err pulse.
- Undefined: addresses pass to memory unmodified, and bit 0 is not checked.

Test Plan:
1. Reset with no requests -> all outputs 0; state stays IDLE with pipe_stall=0 for 10 cycles.
2. Read at addr 0x0010 with mem_done=1 in the first ISSUE cycle and mem_rdata=0xBEEF -> pipe_stall=1 for 2 cycles, resp_valid pulse in cycle 3, rdata=0xBEEF, mem_rd high for exactly 1 cycle.
3. Write 0x1234 to 0x0020 with mem_stall high for 3 cycles, then accepted, then mem_done 2 cycles later -> mem_wr high for 4 cycles, addr/wdata stable throughout, resp_valid with resp_err=0, rdata unchanged.
4. Read, memory never responds, TIMEOUT=64 -> ERR reached on the 64th ISSUE/WAIT cycle, resp_valid=resp_err=1, err_sticky=1 and still 1 after 5 further good accesses, until rst.
5. rst asserted in the 2nd WAIT cycle of a read -> next cycle state IDLE, mem_rd=0, pipe_stall=0, rdata=0, and a late mem_done is ignored.
6. With MEM_MISALIGN_CHK_EN, read at 0x0011 -> mem_rd never asserted, resp_err pulse 1 cycle after the request. Without the macro, the same stimulus performs a normal read of 0x0011.
